// File: rtl/guess_pkg.sv
// rtl/guess_pkg.sv - shared types and constants for the guess evaluator
package guess_pkg;

    localparam int DIGIT_W    = 4;
    localparam int MAX_DIGITS = 3;

    typedef enum logic [1:0] {
        RES_NONE    = 2'b00,
        RES_LOW     = 2'b01,
        RES_HIGH    = 2'b10,
        RES_CORRECT = 2'b11
    } result_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COMPARE,
        ST_REPORT,
        ST_DONE
    } state_t;

    // A digit count of zero still plays one digit.
    function automatic logic [1:0] clamp_digits(input logic [1:0] md);
        return (md == 2'd0) ? 2'd1 : md;
    endfunction

endpackage

// File: rtl/guess_evaluator_if.sv
// rtl/guess_evaluator_if.sv - guess/result handshake bundle; carries match_mask under GUESS_MATCH_MASK_EN
interface guess_evaluator_if
    import guess_pkg::*;
#(
    parameter int ATTEMPT_W = 3
);
    logic [1:0]           max_digits;
    logic [DIGIT_W-1:0]   secret_digit_1;
    logic [DIGIT_W-1:0]   secret_digit_2;
    logic [DIGIT_W-1:0]   secret_digit_3;
    logic [DIGIT_W-1:0]   guess_digit_1;
    logic [DIGIT_W-1:0]   guess_digit_2;
    logic [DIGIT_W-1:0]   guess_digit_3;
    logic                 guess_valid;
    logic                 guess_ready;
    logic                 result_valid;
    logic                 result_ready;
    result_t              result_code;
    logic [ATTEMPT_W-1:0] attempts_used;
    logic                 game_over;
    logic                 game_won;
`ifdef GUESS_MATCH_MASK_EN
    logic [MAX_DIGITS-1:0] match_mask;
`endif

    modport master (
        output max_digits, secret_digit_1, secret_digit_2, secret_digit_3,
        output guess_digit_1, guess_digit_2, guess_digit_3, guess_valid, result_ready,
        input  guess_ready, result_valid, result_code, attempts_used, game_over, game_won
`ifdef GUESS_MATCH_MASK_EN
        , input match_mask
`endif
    );

    modport slave (
        input  max_digits, secret_digit_1, secret_digit_2, secret_digit_3,
        input  guess_digit_1, guess_digit_2, guess_digit_3, guess_valid, result_ready,
        output guess_ready, result_valid, result_code, attempts_used, game_over, game_won
`ifdef GUESS_MATCH_MASK_EN
        , output match_mask
`endif
    );

endinterface

// File: rtl/guess_evaluator.sv
// rtl/guess_evaluator.sv - digit-serial guess comparator with attempt tracking; GUESS_MATCH_MASK_EN adds match_mask
module guess_evaluator
    import guess_pkg::*;
#(
    parameter int MAX_ATTEMPTS = 7,
    parameter int ATTEMPT_W    = 3
) (
    input  logic               clk,
    input  logic               restart,
    guess_evaluator_if.slave   bus
);

    localparam logic [ATTEMPT_W-1:0] MAX_CNT = ATTEMPT_W'(MAX_ATTEMPTS);

    state_t                                 r_state;
    logic [MAX_DIGITS-1:0][DIGIT_W-1:0]     r_guess;
    logic [MAX_DIGITS-1:0][DIGIT_W-1:0]     r_secret;
    logic [1:0]                             r_index;
    result_t                                r_code;
    logic [ATTEMPT_W-1:0]                   r_attempts;
    logic                                   r_guess_ready;
    logic                                   r_result_valid;
    logic                                   r_game_over;
    logic                                   r_game_won;
`ifdef GUESS_MATCH_MASK_EN
    logic [MAX_DIGITS-1:0]                  r_mask;
`endif

    logic [1:0]           w_count;
    logic [DIGIT_W-1:0]   w_g;
    logic [DIGIT_W-1:0]   w_s;
    logic [ATTEMPT_W-1:0] w_attempts_next;

    assign w_count         = clamp_digits(bus.max_digits);
    assign w_g             = r_guess[r_index];
    assign w_s             = r_secret[r_index];
    assign w_attempts_next = (r_attempts == MAX_CNT) ? r_attempts : r_attempts + 1'b1;

    always_ff @(posedge clk or posedge restart) begin
        if (restart) begin
            r_state        <= ST_IDLE;
            r_guess        <= '0;
            r_secret       <= '0;
            r_index        <= 2'd0;
            r_code         <= RES_NONE;
            r_attempts     <= '0;
            r_guess_ready  <= 1'b1;
            r_result_valid <= 1'b0;
            r_game_over    <= 1'b0;
            r_game_won     <= 1'b0;
`ifdef GUESS_MATCH_MASK_EN
            r_mask         <= '0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.guess_valid) begin
                        r_guess       <= {bus.guess_digit_3, bus.guess_digit_2, bus.guess_digit_1};
                        r_secret      <= {bus.secret_digit_3, bus.secret_digit_2, bus.secret_digit_1};
                        r_index       <= w_count - 2'd1;
                        r_code        <= RES_NONE;
                        r_guess_ready <= 1'b0;
                        r_state       <= ST_COMPARE;
`ifdef GUESS_MATCH_MASK_EN
                        r_mask        <= '0;
`endif
                    end
                end
                ST_COMPARE: begin
`ifdef GUESS_MATCH_MASK_EN
                    // Walk every active digit; only the first mismatch decides the code.
                    if (w_g == w_s)
                        r_mask[r_index] <= 1'b1;
                    else if (r_code == RES_NONE)
                        r_code <= (w_g > w_s) ? RES_HIGH : RES_LOW;
                    if (r_index == 2'd0) begin
                        if (r_code == RES_NONE && w_g == w_s)
                            r_code <= RES_CORRECT;
                        r_result_valid <= 1'b1;
                        r_state        <= ST_REPORT;
                    end else begin
                        r_index <= r_index - 2'd1;
                    end
`else
                    if (w_g > w_s) begin
                        r_code         <= RES_HIGH;
                        r_result_valid <= 1'b1;
                        r_state        <= ST_REPORT;
                    end else if (w_g < w_s) begin
                        r_code         <= RES_LOW;
                        r_result_valid <= 1'b1;
                        r_state        <= ST_REPORT;
                    end else if (r_index == 2'd0) begin
                        r_code         <= RES_CORRECT;
                        r_result_valid <= 1'b1;
                        r_state        <= ST_REPORT;
                    end else begin
                        r_index <= r_index - 2'd1;
                    end
`endif
                end
                ST_REPORT: begin
                    if (bus.result_ready) begin
                        r_attempts     <= w_attempts_next;
                        r_result_valid <= 1'b0;
                        if (r_code == RES_CORRECT) begin
                            r_game_won  <= 1'b1;
                            r_game_over <= 1'b1;
                            r_state     <= ST_DONE;
                        end else if (w_attempts_next == MAX_CNT) begin
                            r_game_over <= 1'b1;
                            r_state     <= ST_DONE;
                        end else begin
                            r_guess_ready <= 1'b1;
                            r_state       <= ST_IDLE;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_DONE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.guess_ready   = r_guess_ready;
    assign bus.result_valid  = r_result_valid;
    assign bus.result_code   = r_code;
    assign bus.attempts_used = r_attempts;
    assign bus.game_over     = r_game_over;
    assign bus.game_won      = r_game_won;
`ifdef GUESS_MATCH_MASK_EN
    assign bus.match_mask    = r_mask;
`endif

endmodule
